bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter DIGITS, default 2, number of cascaded BCD decade digits, legal range 1..4.
REQ-002 CLK  input  1  system clock, all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 EN  input  1  count-tick qualifier, sampled each rising CLK edge, active-high.
REQ-005 START  input  1  load DIN and begin countdown, active-high, sampled each rising CLK edge.
REQ-006 STOP  input  1  abort countdown and return to IDLE holding current value, active-high.
REQ-007 DIN  input  4*DIGITS  BCD preset, digit 0 in bits [3:0].
REQ-008 BCD  output  4*DIGITS  current count, registered.
REQ-009 TC  output  1  terminal-count pulse, one CLK cycle, registered.
REQ-010 DONE  output  1  high while in EXPIRED state, registered.
REQ-011 BUSY  output  1  high while in RUN state, registered.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and EXPIRED.
REQ-013 IDLE: START -> load DIN, go RUN; otherwise hold BCD.
REQ-014 RUN: EN high -> decrement BCD by one; STOP -> IDLE, BCD held; START -> reload DIN, stay RUN.
REQ-015 Digit i SHALL decrement only when EN is high and all digits below i are 0; a digit at 0 that decrements SHALL wrap to 9.
REQ-016 Decrement from value 1 to 0 SHALL pulse TC in the same cycle BCD becomes 0 and move to EXPIRED.
REQ-017 EXPIRED: DONE high, BCD held at 0; START -> load DIN, go RUN; STOP -> IDLE.
REQ-018 Loaded digits greater than 9 SHALL be clamped to 9 at load time.
REQ-019 START with DIN equal to all-zero SHALL load 0, pulse TC next cycle and enter EXPIRED, without decrementing.
REQ-020 Priority on a single edge: STOP over START over EN.
REQ-021 EN in IDLE or EXPIRED SHALL have no effect.
REQ-022 Latency: BCD, TC, DONE and BUSY SHALL reflect a sampled input on the first rising edge after it.

Reset
REQ-023 RST low SHALL asynchronously force BCD=0, TC=0, DONE=0, BUSY=0 and state IDLE, including mid-countdown.
REQ-024 After RST deasserts, the first START SHALL behave per REQ-013 with no residual TC.

Configuration
REQ-025 Macro BCD_DOWN_TIMER_AUTORELOAD_EN SHALL select reload-on-expiry behaviour.
REQ-026 With the macro defined, a decrement to 0 SHALL pulse TC, reload the last loaded preset on the same edge and stay RUN; EXPIRED is unreachable and DONE stays 0.
REQ-027 Without the macro, behaviour is per REQ-016 and REQ-017.

Verification
REQ-028 DIGITS=2, START with DIN=0x12, EN high 12 cycles -> BCD 11,10,09..01,00; TC pulse on the edge BCD becomes 00; DONE high after.
REQ-029 DIN=0x10, single EN -> BCD=0x09; digit 1 borrows, digit 0 wraps 0->9.
REQ-030 DIN=0x5F -> BCD=0x59 after load (clamp).
REQ-031 RUN at BCD=0x07, RST low for half cycle -> BCD=0x00, BUSY=0, DONE=0 immediately, no TC.
REQ-032 START, STOP and EN high on the same edge in RUN -> IDLE, BCD unchanged.
REQ-033 Autoreload build, DIN=0x03, EN high 7 cycles -> BCD 02,01,00->03 reload, TC pulses twice, BUSY stays 1.

Source files
------------

// File: rtl/bcd_down_timer.sv
// Cascaded BCD down-counter with IDLE/RUN/EXPIRED control and a terminal-count pulse.
// Define BCD_DOWN_TIMER_AUTORELOAD_EN to reload the preset on expiry instead of stopping.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [4*DIGITS-1:0]   i_din,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_tc,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_bcd;
  logic [W-1:0]   w_bcd_nxt;
  logic [W-1:0]   r_preset;
  logic [W-1:0]   w_preset_nxt;
  logic           w_tc_nxt;
  logic           r_tc;
  logic           r_done;
  logic           r_busy;

  // Saturate any non-decimal nibble to 9.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple-borrow decrement: a digit moves only when every lower digit is 0.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_bcd_nxt    = r_bcd;
    w_preset_nxt = r_preset;
    w_tc_nxt     = 1'b0;
    if (i_stop) begin
      w_state_nxt = S_IDLE;
    end else if (i_start) begin
      w_preset_nxt = clamp_bcd(i_din);
      w_bcd_nxt    = clamp_bcd(i_din);
      w_state_nxt  = S_RUN;
    end else if (r_state == S_RUN) begin
      // A zero preset expires on the cycle after load without needing EN.
      if ((r_bcd == '0) || (i_en && (r_bcd == W'(1)))) begin
        w_tc_nxt = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        w_bcd_nxt   = r_preset;
        w_state_nxt = S_RUN;
`else
        w_bcd_nxt   = '0;
        w_state_nxt = S_EXPIRED;
`endif
      end else if (i_en) begin
        w_bcd_nxt = dec_bcd(r_bcd);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_bcd    <= '0;
      r_preset <= '0;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bcd    <= w_bcd_nxt;
      r_preset <= w_preset_nxt;
      r_tc     <= w_tc_nxt;
      r_done   <= (w_state_nxt == S_EXPIRED);
      r_busy   <= (w_state_nxt == S_RUN);
    end
  end

  assign o_bcd  = r_bcd;
  assign o_tc   = r_tc;
  assign o_done = r_done;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed test of bcd_down_timer (DIGITS=2); autoreload vectors apply when
// BCD_DOWN_TIMER_AUTORELOAD_EN is defined.
module tb_bcd_down_timer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       stop;
  logic [7:0] din;
  logic [7:0] bcd;
  logic       tc;
  logic       done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_cd [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                              8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] exp_ar [7]  = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};
  logic       exp_art [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  bcd_down_timer #(.DIGITS(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_start (start),
    .i_stop  (stop),
    .i_din   (din),
    .o_bcd   (bcd),
    .o_tc    (tc),
    .o_done  (done),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic etc, input logic edone, input logic ebusy);
    chk({tag, ".tc"}, {15'd0, tc}, {15'd0, etc});
    chk({tag, ".done"}, {15'd0, done}, {15'd0, edone});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, ebusy});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; din = 8'h00;
    #12;
    chk("rst.bcd", {8'd0, bcd}, 16'h0000);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifndef BCD_DOWN_TIMER_AUTORELOAD_EN
    // Full countdown from 12 to expiry
    din = 8'h12; start = 1'b1;
    step();
    start = 1'b0;
    chk("load12.bcd", {8'd0, bcd}, 16'h0012);
    chk_flags("load12", 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("cd%0d.bcd", k), {8'd0, bcd}, {8'd0, exp_cd[k]});
      chk($sformatf("cd%0d.tc", k), {15'd0, tc}, {15'd0, (k == 11)});
    end
    chk_flags("expired", 1'b1, 1'b1, 1'b0);
    step();
    chk("exp_en.bcd", {8'd0, bcd}, 16'h0000);
    chk_flags("exp_en", 1'b0, 1'b1, 1'b0);
    en = 1'b0;

    // Zero preset expires next cycle without EN
    din = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero.bcd", {8'd0, bcd}, 16'h0000);
    chk_flags("zero_load", 1'b0, 1'b0, 1'b1);
    step();
    chk_flags("zero_tc", 1'b1, 1'b1, 1'b0);
    step();
    chk_flags("zero_after", 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_flags("exp_stop", 1'b0, 1'b0, 1'b0);
`else
    din = 8'h03; start = 1'b1;
    step();
    start = 1'b0;
    chk("ar_load.bcd", {8'd0, bcd}, 16'h0003);
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("ar%0d.bcd", k), {8'd0, bcd}, {8'd0, exp_ar[k]});
      chk_flags($sformatf("ar%0d", k), exp_art[k], 1'b0, 1'b1);
    end
    en = 1'b0;
`endif

    // Borrow across digits
    din = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    chk("b10.bcd", {8'd0, bcd}, 16'h0010);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("b09.bcd", {8'd0, bcd}, 16'h0009);

    din = 8'hFA; start = 1'b1;
    step();
    chk("clampFA.bcd", {8'd0, bcd}, 16'h0099);
    din = 8'h5F;
    step();
    start = 1'b0;
    chk("clamp5F.bcd", {8'd0, bcd}, 16'h0059);

    // STOP beats START and EN
    din = 8'h33; start = 1'b1; stop = 1'b1; en = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("prio.bcd", {8'd0, bcd}, 16'h0059);
    chk_flags("prio", 1'b0, 1'b0, 1'b0);
    step();
    en = 1'b0;
    chk("idle_en.bcd", {8'd0, bcd}, 16'h0059);

    din = 8'h05; start = 1'b1;
    step();
    din = 8'h08; en = 1'b1;
    step();
    start = 1'b0; en = 1'b0;
    chk("start_over_en.bcd", {8'd0, bcd}, 16'h0008);

    // Asynchronous reset mid-countdown
    din = 8'h07; start = 1'b1;
    step();
    start = 1'b0;
    chk("pre_rst.bcd", {8'd0, bcd}, 16'h0007);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.bcd", {8'd0, bcd}, 16'h0000);
    chk_flags("arst", 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0);
    din = 8'h02; start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_load.bcd", {8'd0, bcd}, 16'h0002);
    chk_flags("post_rst_load", 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
